// File: rtl/neuron_pkg.sv
// Shared types and sizes for the neuron multiplier, accumulator and activation stages.
package neuron_pkg;

  localparam int NEURON_LANES = 33;
  localparam int NEURON_WIDTH = 32;

  typedef logic [NEURON_LANES-1:0][NEURON_WIDTH-1:0] product_vec_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } acc_state_t;

endpackage

// File: rtl/saturate_signed.sv
// Combinational signed clamp from IN_W bits down to OUT_W bits, flagging any clipping.
module saturate_signed #(
  parameter int IN_W  = 38,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  d,
  output logic [OUT_W-1:0] q,
  output logic             sat
);

  logic             sign;
  logic [IN_W-OUT_W:0] top;

  // The value fits iff every bit from the sign down to bit OUT_W-1 agrees.
  assign sign = d[IN_W-1];
  assign top  = d[IN_W-1:OUT_W-1];
  assign sat  = !((&top) || (~|top));
  assign q    = sat ? {sign, {(OUT_W-1){~sign}}} : d[OUT_W-1:0];

endmodule

// File: rtl/neuron_accumulator.sv
// Serial reduction of one product vector (inputs + bias) into a saturated pre-activation sum.
//
// state | meaning
// IDLE  | ready for a new product vector
// ACCUM | adding one captured lane per cycle
// DONE  | result presented, waiting for out_ready
module neuron_accumulator
  import neuron_pkg::*;
#(
  parameter int LANES     = NEURON_LANES,
  parameter int WIDTH     = NEURON_WIDTH,
  parameter int ACC_WIDTH = WIDTH + $clog2(LANES)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [LANES-1:0][WIDTH-1:0]  in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             sum,
  output logic                         sat
);

  localparam int IDX_W = $clog2(LANES);

  acc_state_t                  state, state_nxt;
  logic [LANES-1:0][WIDTH-1:0] vec;
  logic [ACC_WIDTH-1:0]        acc;
  logic [ACC_WIDTH-1:0]        acc_nxt;
  logic [IDX_W-1:0]            idx;
  logic [WIDTH-1:0]            lane;
  logic                        last_lane;
  logic [WIDTH-1:0]            sum_clamped;
  logic                        sat_clamped;

  assign lane      = vec[idx];
  assign acc_nxt   = acc + {{(ACC_WIDTH-WIDTH){lane[WIDTH-1]}}, lane};
  assign last_lane = (idx == IDX_W'(LANES-1));

  saturate_signed #(
    .IN_W  (ACC_WIDTH),
    .OUT_W (WIDTH)
  ) u_sat (
    .d   (acc_nxt),
    .q   (sum_clamped),
    .sat (sat_clamped)
  );

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (last_lane) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vec <= '0;
      acc <= '0;
      idx <= '0;
      sum <= '0;
      sat <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        vec <= in;
        acc <= '0;
        idx <= '0;
      end else if (state == ACCUM) begin
        acc <= acc_nxt;
        // Saturate only once, on the exact full-width total.
        if (last_lane) begin
          idx <= '0;
          sum <= sum_clamped;
          sat <= sat_clamped;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

endmodule
